rename_reg_file: RTL and testbench

RENAME_REG_FILE -- requirements
Module: rename_reg_file

---
 rtl/rename_reg_file_if.sv | 48 ++++
 rtl/rename_reg_file.sv | 142 ++++++++++++++
 tb/tb_rename_reg_file.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_reg_file_if.sv
// Dispatch, rename, checkpoint, commit and recovery signals of the rename register file.
// The master drives requests; the slave (register file) returns operands and checkpoint status.
interface rename_reg_file_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned ROB_W  = 4,
   parameter int unsigned CKPT_N = 4
);
   localparam int unsigned REG_W  = $clog2(NREG);
   localparam int unsigned CKPT_W = $clog2(CKPT_N);

   logic              rdy;
   logic [REG_W-1:0]  rs1;
   logic [REG_W-1:0]  rs2;
   logic [XLEN-1:0]   vj;
   logic [XLEN-1:0]   vk;
   logic              qj_busy;
   logic              qk_busy;
   logic [ROB_W-1:0]  qj;
   logic [ROB_W-1:0]  qk;
   logic              ren_en;
   logic [REG_W-1:0]  ren_rd;
   logic [ROB_W-1:0]  ren_tag;
   logic              ckpt_alloc;
   logic [CKPT_W-1:0] ckpt_id;
   logic              ckpt_full;
   logic [CKPT_W:0]   ckpt_count;
   logic              ckpt_release;
   logic              cm_en;
   logic [REG_W-1:0]  cm_rd;
   logic [ROB_W-1:0]  cm_tag;
   logic [XLEN-1:0]   cm_val;
   logic              recover;
   logic [CKPT_W-1:0] recover_id;
   logic              flush;

   modport master (
      output rdy, rs1, rs2, ren_en, ren_rd, ren_tag, ckpt_alloc, ckpt_release,
             cm_en, cm_rd, cm_tag, cm_val, recover, recover_id, flush,
      input  vj, vk, qj_busy, qk_busy, qj, qk, ckpt_id, ckpt_full, ckpt_count
   );

   modport slave (
      input  rdy, rs1, rs2, ren_en, ren_rd, ren_tag, ckpt_alloc, ckpt_release,
             cm_en, cm_rd, cm_tag, cm_val, recover, recover_id, flush,
      output vj, vk, qj_busy, qk_busy, qj, qk, ckpt_id, ckpt_full, ckpt_count
   );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with rename (busy/tag) table, commit bypass and a circular
// buffer of rename-table checkpoints for branch recovery.
module rename_reg_file #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned ROB_W  = 4,
   parameter int unsigned CKPT_N = 4
) (
   input logic               clk,
   input logic               rst,
   rename_reg_file_if.slave  rf_io
);
   localparam int unsigned CKPT_W = $clog2(CKPT_N);
   localparam logic [CKPT_W:0] CntFull = (CKPT_W+1)'(CKPT_N);

   logic [XLEN-1:0]   v_q       [NREG];
   logic [XLEN-1:0]   v_d       [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [ROB_W-1:0]  tag_q     [NREG];
   logic [ROB_W-1:0]  tag_d     [NREG];
   logic [NREG-1:0]   ck_busy_q [CKPT_N];
   logic [NREG-1:0]   ck_busy_d [CKPT_N];
   logic [ROB_W-1:0]  ck_tag_q  [CKPT_N][NREG];
   logic [ROB_W-1:0]  ck_tag_d  [CKPT_N][NREG];
   logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CKPT_W:0]   count_q, count_d;
   logic [CKPT_W-1:0] rec_span, rec_off;
   logic              full, do_alloc, do_rel, rec_live;

   assign full             = (count_q == CntFull);
   assign rf_io.ckpt_id    = tail_q;
   assign rf_io.ckpt_full  = full;
   assign rf_io.ckpt_count = count_q;

   // x0 is never written nor renamed, so its stored zeros need no special read path.
   always_comb begin
      rf_io.vj      = v_q[rf_io.rs1];
      rf_io.qj_busy = busy_q[rf_io.rs1];
      rf_io.qj      = tag_q[rf_io.rs1];
      if (rf_io.cm_en && rf_io.cm_rd == rf_io.rs1 && busy_q[rf_io.rs1] &&
          tag_q[rf_io.rs1] == rf_io.cm_tag) begin
         rf_io.qj_busy = 1'b0;
         rf_io.vj      = rf_io.cm_val;
      end
      rf_io.vk      = v_q[rf_io.rs2];
      rf_io.qk_busy = busy_q[rf_io.rs2];
      rf_io.qk      = tag_q[rf_io.rs2];
      if (rf_io.cm_en && rf_io.cm_rd == rf_io.rs2 && busy_q[rf_io.rs2] &&
          tag_q[rf_io.rs2] == rf_io.cm_tag) begin
         rf_io.qk_busy = 1'b0;
         rf_io.vk      = rf_io.cm_val;
      end
   end

   always_comb begin
      v_d       = v_q;
      busy_d    = busy_q;
      tag_d     = tag_q;
      ck_busy_d = ck_busy_q;
      ck_tag_d  = ck_tag_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      do_alloc  = 1'b0;
      do_rel    = 1'b0;
      rec_span  = rf_io.recover_id - head_q + CKPT_W'(1);

      if (rf_io.cm_en && rf_io.cm_rd != '0) v_d[rf_io.cm_rd] = rf_io.cm_val;

      // Scrub snapshots so a later recover does not resurrect an already-committed producer.
      if (rf_io.cm_en) begin
         for (int s = 0; s < CKPT_N; s++) begin
            if (ck_busy_q[CKPT_W'(s)][rf_io.cm_rd] &&
                ck_tag_q[CKPT_W'(s)][rf_io.cm_rd] == rf_io.cm_tag) begin
               ck_busy_d[CKPT_W'(s)][rf_io.cm_rd] = 1'b0;
            end
         end
      end

      if (rf_io.flush) begin
         busy_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (rf_io.recover) begin
         busy_d  = ck_busy_d[rf_io.recover_id];
         tag_d   = ck_tag_q[rf_io.recover_id];
         tail_d  = rf_io.recover_id + CKPT_W'(1);
         count_d = (rec_span == '0) ? CntFull : {1'b0, rec_span};
         if (rf_io.ckpt_release) begin
            head_d  = head_q + CKPT_W'(1);
            count_d = count_d - (CKPT_W+1)'(1);
         end
      end else begin
         if (rf_io.cm_en && busy_q[rf_io.cm_rd] && tag_q[rf_io.cm_rd] == rf_io.cm_tag &&
             !(rf_io.ren_en && rf_io.ren_rd == rf_io.cm_rd)) begin
            busy_d[rf_io.cm_rd] = 1'b0;
         end
         if (rf_io.ren_en && rf_io.ren_rd != '0) begin
            busy_d[rf_io.ren_rd] = 1'b1;
            tag_d[rf_io.ren_rd]  = rf_io.ren_tag;
         end
         do_alloc = rf_io.ckpt_alloc && !full;
         do_rel   = rf_io.ckpt_release && (count_q != '0);
         if (do_alloc) begin
            ck_busy_d[tail_q] = busy_d;
            ck_tag_d[tail_q]  = tag_d;
            tail_d            = tail_q + CKPT_W'(1);
         end
         if (do_rel) head_d = head_q + CKPT_W'(1);
         count_d = count_q + (CKPT_W+1)'(do_alloc) - (CKPT_W+1)'(do_rel);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q       <= '{default: '0};
         busy_q    <= '0;
         tag_q     <= '{default: '0};
         ck_busy_q <= '{default: '0};
         ck_tag_q  <= '{default: '0};
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else if (rf_io.rdy) begin
         v_q       <= v_d;
         busy_q    <= busy_d;
         tag_q     <= tag_d;
         ck_busy_q <= ck_busy_d;
         ck_tag_q  <= ck_tag_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   assign rec_off  = rf_io.recover_id - head_q;
   assign rec_live = ({1'b0, rec_off} < count_q);

   rec_id_live_a: assert property (@(posedge clk) disable iff (rst)
      (rf_io.rdy && rf_io.recover && !rf_io.flush) |-> rec_live);
endmodule

// File: tb/tb_rename_reg_file.sv
// Random and directed bench for rename_reg_file against a queue-based model of the
// register file and its live checkpoint list.
module tb_rename_reg_file;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned ROB_W  = 4;
   localparam int unsigned CKPT_N = 4;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CKPT_W = 2;

   typedef struct packed {
      logic [CKPT_W-1:0]            id;
      logic [NREG-1:0]              b;
      logic [NREG-1:0][ROB_W-1:0]   t;
   } ck_t;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   rename_reg_file_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .CKPT_N(CKPT_N)) rf ();

   rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .CKPT_N(CKPT_N)) dut (
      .clk   (clk),
      .rst   (rst),
      .rf_io (rf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: register values, busy/tag table, oldest-first list of live checkpoints.
   logic [XLEN-1:0]            mv [NREG];
   logic [NREG-1:0]            mb;
   logic [NREG-1:0][ROB_W-1:0] mq;
   ck_t                        ckq [$];
   int                         m_tail;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void mread(input logic [REG_W-1:0] rs, output logic [XLEN-1:0] v,
                                 output logic b, output logic [ROB_W-1:0] q);
      v = mv[rs];
      b = mb[rs];
      q = mq[rs];
      if (rs == '0) begin
         v = '0;
         b = 1'b0;
      end else if (rf.cm_en && rf.cm_rd == rs && mb[rs] && mq[rs] == rf.cm_tag) begin
         b = 1'b0;
         v = rf.cm_val;
      end
   endfunction

   function automatic void compare_all();
      logic [XLEN-1:0]  v;
      logic             b;
      logic [ROB_W-1:0] q;
      mread(rf.rs1, v, b, q);
      chk("vj", 64'(rf.vj), 64'(v));
      chk("qj_busy", 64'(rf.qj_busy), 64'(b));
      if (b) chk("qj", 64'(rf.qj), 64'(q));
      mread(rf.rs2, v, b, q);
      chk("vk", 64'(rf.vk), 64'(v));
      chk("qk_busy", 64'(rf.qk_busy), 64'(b));
      if (b) chk("qk", 64'(rf.qk), 64'(q));
      chk("ckpt_id", 64'(rf.ckpt_id), 64'(m_tail));
      chk("ckpt_count", 64'(rf.ckpt_count), 64'(ckq.size()));
      chk("ckpt_full", 64'(rf.ckpt_full), 64'(ckq.size() == CKPT_N));
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NREG; i++) mv[i] = '0;
      mb     = '0;
      mq     = '0;
      ckq    = {};
      m_tail = 0;
   endfunction

   function automatic void model_update();
      int  n0;
      int  k;
      ck_t e;
      if (rst) begin
         model_reset();
         return;
      end
      if (!rf.rdy) return;
      n0 = ckq.size();
      if (rf.cm_en && rf.cm_rd != '0) mv[rf.cm_rd] = rf.cm_val;
      if (rf.cm_en) begin
         foreach (ckq[i]) begin
            e = ckq[i];
            if (e.b[rf.cm_rd] && e.t[rf.cm_rd] == rf.cm_tag) e.b[rf.cm_rd] = 1'b0;
            ckq[i] = e;
         end
      end
      if (rf.flush) begin
         mb     = '0;
         ckq    = {};
         m_tail = 0;
      end else if (rf.recover) begin
         k = -1;
         foreach (ckq[i]) if (ckq[i].id == rf.recover_id) k = i;
         if (k < 0) begin
            chk("recover_live_in_model", 64'(0), 64'(1));
         end else begin
            mb = ckq[k].b;
            mq = ckq[k].t;
            while (ckq.size() > k + 1) ckq.delete(ckq.size() - 1);
            m_tail = (int'(rf.recover_id) + 1) % CKPT_N;
            if (rf.ckpt_release) ckq.delete(0);
         end
      end else begin
         if (rf.cm_en && mb[rf.cm_rd] && mq[rf.cm_rd] == rf.cm_tag &&
             !(rf.ren_en && rf.ren_rd == rf.cm_rd)) mb[rf.cm_rd] = 1'b0;
         if (rf.ren_en && rf.ren_rd != '0) begin
            mb[rf.ren_rd] = 1'b1;
            mq[rf.ren_rd] = rf.ren_tag;
         end
         if (rf.ckpt_alloc && n0 < CKPT_N) begin
            e.id = CKPT_W'(m_tail);
            e.b  = mb;
            e.t  = mq;
            ckq.push_back(e);
            m_tail = (m_tail + 1) % CKPT_N;
         end
         if (rf.ckpt_release && n0 > 0) ckq.delete(0);
      end
   endfunction

   task automatic idle();
      rst             = 1'b0;
      rf.rdy          = 1'b1;
      rf.rs1          = '0;
      rf.rs2          = '0;
      rf.ren_en       = 1'b0;
      rf.ren_rd       = '0;
      rf.ren_tag      = '0;
      rf.ckpt_alloc   = 1'b0;
      rf.ckpt_release = 1'b0;
      rf.cm_en        = 1'b0;
      rf.cm_rd        = '0;
      rf.cm_tag       = '0;
      rf.cm_val       = '0;
      rf.recover      = 1'b0;
      rf.recover_id   = '0;
      rf.flush        = 1'b0;
   endtask

   // Inputs are set at the falling edge; outputs are checked 1 time unit later.
   task automatic step(input bit do_chk);
      #1;
      if (do_chk) compare_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic ren(input int rd, input int tag);
      idle();
      rf.ren_en  = 1'b1;
      rf.ren_rd  = REG_W'(rd);
      rf.ren_tag = ROB_W'(tag);
   endtask

   task automatic cm(input int rd, input int tag, input logic [XLEN-1:0] val);
      rf.cm_en  = 1'b1;
      rf.cm_rd  = REG_W'(rd);
      rf.cm_tag = ROB_W'(tag);
      rf.cm_val = val;
   endtask

   initial begin
      model_reset();
      idle();
      rst = 1'b1;
      @(negedge clk);
      step(0);
      idle();
      #1;
      chk("reset_count", 64'(rf.ckpt_count), 64'(0));
      chk("reset_id", 64'(rf.ckpt_id), 64'(0));
      chk("reset_full", 64'(rf.ckpt_full), 64'(0));
      step(1);

      // Commit bypass
      ren(5, 3); step(1);
      idle(); cm(5, 3, 32'hDEAD); rf.rs1 = 5; #1;
      chk("bypass_busy", 64'(rf.qj_busy), 64'(0));
      chk("bypass_val", 64'(rf.vj), 64'hDEAD);
      step(1);
      idle(); rf.rs1 = 5; #1;
      chk("bypass_after_busy", 64'(rf.qj_busy), 64'(0));
      chk("bypass_after_val", 64'(rf.vj), 64'hDEAD);
      step(1);

      // Stale commit
      ren(5, 3); step(1);
      ren(5, 7); step(1);
      idle(); cm(5, 3, 32'h11); step(1);
      idle(); rf.rs1 = 5; #1;
      chk("stale_val", 64'(rf.vj), 64'h11);
      chk("stale_busy", 64'(rf.qj_busy), 64'(1));
      chk("stale_tag", 64'(rf.qj), 64'(7));
      step(1);

      // Same-cycle rename beats commit clear
      ren(6, 2); step(1);
      ren(6, 9); cm(6, 2, 32'h66); step(1);
      idle(); rf.rs1 = 6; #1;
      chk("conflict_busy", 64'(rf.qj_busy), 64'(1));
      chk("conflict_tag", 64'(rf.qj), 64'(9));
      step(1);

      // Checkpoint recover
      idle(); rf.flush = 1'b1; step(1);
      ren(1, 1); step(1);
      idle(); rf.ckpt_alloc = 1'b1; #1;
      chk("alloc0_id", 64'(rf.ckpt_id), 64'(0));
      step(1);
      ren(2, 2); step(1);
      idle(); rf.ckpt_alloc = 1'b1; step(1);
      ren(3, 3); step(1);
      idle(); rf.recover = 1'b1; rf.recover_id = 0; step(1);
      idle(); rf.rs1 = 1; rf.rs2 = 2; #1;
      chk("rec_x1_busy", 64'(rf.qj_busy), 64'(1));
      chk("rec_x1_tag", 64'(rf.qj), 64'(1));
      chk("rec_x2_busy", 64'(rf.qk_busy), 64'(0));
      chk("rec_count", 64'(rf.ckpt_count), 64'(1));
      chk("rec_id", 64'(rf.ckpt_id), 64'(1));
      rf.rs1 = 3; #1;
      chk("rec_x3_busy", 64'(rf.qj_busy), 64'(0));
      step(1);

      // Full buffer and snapshot scrub
      idle(); rf.flush = 1'b1; step(1);
      idle(); rf.ckpt_alloc = 1'b1; step(1);
      idle(); rf.ckpt_alloc = 1'b1; step(1);
      ren(4, 5); rf.ckpt_alloc = 1'b1; step(1);
      idle(); rf.ckpt_alloc = 1'b1; step(1);
      idle(); #1;
      chk("full_flag", 64'(rf.ckpt_full), 64'(1));
      rf.ckpt_alloc = 1'b1; step(1);
      idle(); #1;
      chk("full_ignored_count", 64'(rf.ckpt_count), 64'(4));
      chk("full_ignored_id", 64'(rf.ckpt_id), 64'(0));
      ren(4, 6); step(1);
      idle(); cm(4, 5, 32'h44); step(1);
      idle(); rf.recover = 1'b1; rf.recover_id = 2; step(1);
      idle(); rf.rs1 = 4; #1;
      chk("scrub_busy", 64'(rf.qj_busy), 64'(0));
      chk("scrub_val", 64'(rf.vj), 64'h44);
      chk("scrub_count", 64'(rf.ckpt_count), 64'(3));
      step(1);

      // Flush, then reset in a recover cycle
      ren(7, 1); step(1);
      idle(); rf.flush = 1'b1; step(1);
      idle(); rf.rs1 = 7; rf.rs2 = 4; #1;
      chk("flush_count", 64'(rf.ckpt_count), 64'(0));
      chk("flush_busy", 64'(rf.qj_busy), 64'(0));
      chk("flush_keep_v", 64'(rf.vk), 64'h44);
      rf.ckpt_alloc = 1'b1; step(1);
      ren(8, 2); step(1);
      idle(); rf.recover = 1'b1; rf.recover_id = 0; rst = 1'b1; step(1);
      idle(); rf.rs1 = 8; rf.rs2 = 4; #1;
      chk("rst_busy", 64'(rf.qj_busy), 64'(0));
      chk("rst_v", 64'(rf.vk), 64'(0));
      chk("rst_count", 64'(rf.ckpt_count), 64'(0));
      chk("rst_id", 64'(rf.ckpt_id), 64'(0));
      step(1);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         idle();
         rf.rdy          = ($urandom_range(0, 9) != 0);
         rf.rs1          = REG_W'($urandom_range(0, 7));
         rf.rs2          = REG_W'($urandom_range(0, 7));
         rf.ren_en       = ($urandom_range(0, 2) == 0);
         rf.ren_rd       = REG_W'($urandom_range(0, 7));
         rf.ren_tag      = ROB_W'($urandom);
         rf.cm_en        = ($urandom_range(0, 2) == 0);
         rf.cm_rd        = REG_W'($urandom_range(0, 7));
         rf.cm_tag       = $urandom_range(0, 1) ? mq[rf.cm_rd] : ROB_W'($urandom);
         rf.cm_val       = $urandom;
         rf.ckpt_alloc   = ($urandom_range(0, 4) == 0);
         rf.ckpt_release = ($urandom_range(0, 6) == 0);
         if (ckq.size() > 0 && $urandom_range(0, 19) == 0) begin
            rf.recover    = 1'b1;
            rf.recover_id = ckq[$urandom_range(0, ckq.size() - 1)].id;
         end
         rf.flush = ($urandom_range(0, 59) == 0);
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
